// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: internal opcodes, iteration FSM states
// and the mul/div classifier.
package alu_pkg;

  localparam int unsigned OPC_W = 7;

  typedef enum logic [OPC_W-1:0] {
    OP_ADDIU = 7'd3,
    OP_ADDU  = 7'd4,
    OP_SUBU  = 7'd5,
    OP_AND   = 7'd6,
    OP_OR    = 7'd7,
    OP_XOR   = 7'd8,
    OP_SLTU  = 7'd9,
    OP_SLT   = 7'd10,
    OP_SLL   = 7'd11,
    OP_SRL   = 7'd12,
    OP_SRA   = 7'd13,
    OP_SLLV  = 7'd14,
    OP_SRLV  = 7'd15,
    OP_SRAV  = 7'd16,
    OP_MFHI  = 7'd17,
    OP_MFLO  = 7'd18,
    OP_MTHI  = 7'd19,
    OP_MTLO  = 7'd20,
    OP_MULT  = 7'd21,
    OP_MULTU = 7'd22,
    OP_DIV   = 7'd23,
    OP_DIVU  = 7'd24,
    OP_LW    = 7'd47
  } opcode_internal;

  typedef enum logic [1:0] {
    IDLE,
    MUL_ITER,
    DIV_ITER,
    SIGN_FIX
  } state_t;

  function automatic logic is_muldiv(input logic [OPC_W-1:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider with a final sign-fix cycle.
// Results are presented combinationally while done is high.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic               neg_lo, neg_hi, div_op;

  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;

  assign a_neg    = is_signed & a[WIDTH-1];
  assign b_neg    = is_signed & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div & (b == '0);

  assign busy = (state != IDLE);
  assign done = (state == SIGN_FIX);

  // acc_hi:acc_lo is the running product (mul) or remainder:quotient (div)
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
    div_sh  = {acc_hi, acc_lo[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opnd});
    div_sub = div_sh[WIDTH-1:0] - opnd;
  end

  always_comb begin
    prod   = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (div_op) begin
      lo_res = neg_lo ? -acc_lo : acc_lo;
      hi_res = neg_hi ? -acc_hi : acc_hi;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:               if (start) state_nxt = is_div ? DIV_ITER : MUL_ITER;
      MUL_ITER, DIV_ITER: if (count == CW'(1)) state_nxt = SIGN_FIX;
      SIGN_FIX:           state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div_op <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          count  <= CW'(WIDTH);
          div_op <= is_div;
          acc_hi <= '0;
          // Divide by zero runs unsigned on raw a so the loop leaves hi=a, lo=all-ones
          if (is_div) begin
            acc_lo <= div_zero ? a : a_mag;
            opnd   <= b_mag;
            neg_lo <= ~div_zero & (a_neg ^ b_neg);
            neg_hi <= ~div_zero & a_neg;
          end else begin
            acc_lo <= b_mag;
            opnd   <= a_mag;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= 1'b0;
          end
        end
        MUL_ITER: begin
          count            <= count - CW'(1);
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
        end
        DIV_ITER: begin
          count  <= count - CW'(1);
          acc_hi <= div_ge ? div_sub : div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle integer datapath, HI/LO registers and valid/ready
// handshake around the iterative mul/div unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       sa,
  output logic             valid_out,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             negative
);

  logic             accept, md_op, md_start, md_busy, md_done;
  logic [WIDTH-1:0] md_hi, md_lo, res;

  assign ready_out = ~md_busy;
  assign accept    = valid_in & ready_out;
  assign md_op     = is_muldiv(op);
  assign md_start  = accept & md_op;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (md_start),
    .is_div    ((op == OP_DIV) || (op == OP_DIVU)),
    .is_signed ((op == OP_MULT) || (op == OP_DIV)),
    .a         (a),
    .b         (b),
    .busy      (md_busy),
    .done      (md_done),
    .hi_res    (md_hi),
    .lo_res    (md_lo)
  );

  always_comb begin
    res = '0;
    case (op)
      OP_ADDU, OP_ADDIU, OP_LW: res = a + b;
      OP_SUBU: res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLTU: res[0] = (a < b);
      OP_SLT:  res[0] = ($signed(a) < $signed(b));
      OP_SLL:  res = a << sa;
      OP_SRL:  res = a >> sa;
      OP_SRA:  res = $signed(a) >>> sa;
      OP_SLLV: res = a << b[4:0];
      OP_SRLV: res = a >> b[4:0];
      OP_SRAV: res = $signed(a) >>> b[4:0];
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      r         <= '0;
      hi        <= '0;
      lo        <= '0;
      zero      <= 1'b1;
      negative  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (accept && !md_op) begin
        valid_out <= 1'b1;
        case (op)
          OP_MTHI: hi <= a;
          OP_MTLO: lo <= a;
          default: begin
            r        <= res;
            zero     <= (res == '0);
            negative <= res[WIDTH-1];
          end
        endcase
      end
      if (md_done) begin
        hi        <= md_hi;
        lo        <= md_lo;
        valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (32-bit instance plus a 16-bit instance).
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, ready_out, valid_out, zero, negative;
  logic [6:0]  op;
  logic [31:0] a, b, r, hi, lo;
  logic [4:0]  sa;

  logic        valid16, ready16, vout16, zero16, neg16;
  logic [6:0]  op16;
  logic [15:0] a16, b16, r16, hi16, lo16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .OP_W(7)) u32 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .op(op), .a(a), .b(b), .sa(sa), .valid_out(valid_out), .r(r),
    .hi(hi), .lo(lo), .zero(zero), .negative(negative)
  );

  alu_seq #(.WIDTH(16), .OP_W(7)) u16 (
    .clk(clk), .reset(reset), .valid_in(valid16), .ready_out(ready16),
    .op(op16), .a(a16), .b(b16), .sa(5'd0), .valid_out(vout16), .r(r16),
    .hi(hi16), .lo(lo16), .zero(zero16), .negative(neg16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one mul/div op on the 32-bit unit and checks latency and HI/LO.
  task automatic run_md(input string name, input logic [6:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    logic [31:0] r_before;
    int cyc;
    @(negedge clk);
    r_before = r;
    op = o; a = va; b = vb; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    cyc = 0;
    while (!valid_out && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'd33);
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
    check({name, "_r_kept"}, 64'(r), 64'(r_before));
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sa;
    logic [31:0] exp_r;
    string       name;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0]  = '{7'(OP_ADDU),  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, "addu_wrap"};
    vecs[1]  = '{7'(OP_SRA),   32'h80000000, 32'h00000000, 5'd4,  32'hF8000000, "sra"};
    vecs[2]  = '{7'(OP_SLT),   32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, "slt_neg"};
    vecs[3]  = '{7'(OP_ADDIU), 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, "addiu"};
    vecs[4]  = '{7'(OP_LW),    32'h00001000, 32'h00000024, 5'd0,  32'h00001024, "lw_addr"};
    vecs[5]  = '{7'(OP_SUBU),  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, "subu"};
    vecs[6]  = '{7'(OP_AND),   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, "and"};
    vecs[7]  = '{7'(OP_OR),    32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, "or"};
    vecs[8]  = '{7'(OP_XOR),   32'hAAAAAAAA, 32'hFFFF0000, 5'd0,  32'h5555AAAA, "xor"};
    vecs[9]  = '{7'(OP_SLTU),  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, "sltu_big"};
    vecs[10] = '{7'(OP_SLTU),  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000001, "sltu_small"};
    vecs[11] = '{7'(OP_SLT),   32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001, "slt_minmax"};
    vecs[12] = '{7'(OP_SLL),   32'h00000001, 32'h00000000, 5'd31, 32'h80000000, "sll31"};
    vecs[13] = '{7'(OP_SRL),   32'h80000000, 32'h00000000, 5'd4,  32'h08000000, "srl"};
    vecs[14] = '{7'(OP_SLLV),  32'h0000000F, 32'h00000024, 5'd0,  32'h000000F0, "sllv"};
    vecs[15] = '{7'(OP_SRLV),  32'hF0000000, 32'hFFFFFFFC, 5'd0,  32'h0000000F, "srlv"};
    vecs[16] = '{7'(OP_SRAV),  32'h80000000, 32'h0000001F, 5'd0,  32'hFFFFFFFF, "srav"};
    vecs[17] = '{7'd100,       32'h00000005, 32'h00000005, 5'd0,  32'h00000000, "unknown_op"};

    reset = 1'b1; valid_in = 1'b0; op = '0; a = '0; b = '0; sa = '0;
    valid16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    #12;
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_negative", 64'(negative), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back single-cycle table, one op per cycle
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; sa = vecs[i].sa; valid_in = 1'b1;
      @(posedge clk); #1;
      check({vecs[i].name, "_valid"}, 64'(valid_out), 64'd1);
      check({vecs[i].name, "_ready"}, 64'(ready_out), 64'd1);
      check({vecs[i].name, "_r"}, 64'(r), 64'(vecs[i].exp_r));
      check({vecs[i].name, "_zero"}, 64'(zero), 64'(vecs[i].exp_r == 32'h0));
      check({vecs[i].name, "_neg"}, 64'(negative), 64'(vecs[i].exp_r[31]));
    end
    valid_in = 1'b0; sa = '0;
    check("unknown_hi_kept", 64'(hi), 64'd0);
    check("unknown_lo_kept", 64'(lo), 64'd0);
    @(posedge clk); #1;
    check("valid_drops", 64'(valid_out), 64'd0);

    // MTHI/MFHI and MTLO/MFLO
    @(negedge clk);
    op = OP_MTHI; a = 32'h12345678; valid_in = 1'b1;
    @(posedge clk); #1;
    check("mthi_valid", 64'(valid_out), 64'd1);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_r_kept", 64'(r), 64'd0);
    op = OP_MFHI; a = 32'h0;
    @(posedge clk); #1;
    check("mfhi_r", 64'(r), 64'h12345678);
    op = OP_MTLO; a = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("mtlo_lo", 64'(lo), 64'hCAFEF00D);
    op = OP_MFLO; a = 32'h0;
    @(posedge clk); #1;
    check("mflo_r", 64'(r), 64'hCAFEF00D);
    check("mflo_neg", 64'(negative), 64'd1);
    valid_in = 1'b0;

    // Multi-cycle ops
    run_md("mult",      OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_md("multu",     OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA);
    run_md("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_md("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_negb",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_md("divu_zero", OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_md("div_zero",  OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_md("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_md("divu",      OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999);

    // Stall: MFLO held on valid_in behind a DIV
    @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd7; valid_in = 1'b1;
    @(posedge clk); #1;
    op = OP_MFLO; a = 32'h0; b = 32'h0;
    cnt = 0;
    while (!ready_out && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("stall_cycles", 64'(cnt), 64'd33);
    check("stall_div_valid", 64'(valid_out), 64'd1);
    check("stall_div_lo", 64'(lo), 64'd14);
    check("stall_div_hi", 64'(hi), 64'd2);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("stall_mflo_valid", 64'(valid_out), 64'd1);
    check("stall_mflo_r", 64'(r), 64'd14);

    // 16-bit instance: MULTU 0xFFFF * 0xFFFF
    @(negedge clk);
    op16 = OP_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF; valid16 = 1'b1;
    @(posedge clk); #1;
    valid16 = 1'b0;
    cnt = 0;
    while (!vout16 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("w16_latency", 64'(cnt), 64'd17);
    check("w16_hi", 64'(hi16), 64'hFFFE);
    check("w16_lo", 64'(lo16), 64'h0001);

    // Reset asserted mid-MULT
    @(negedge clk);
    op = OP_MULT; a = 32'h00001234; b = 32'h00005678; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", 64'(ready_out), 64'd1);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    #2 reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_out) cnt++;
    end
    check("midrst_no_valid", 64'(cnt), 64'd0);
    check("midrst_hi_after", 64'(hi), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
